// File: rtl/rs_bank.sv
// Reservation-station bank sitting between the issue stage and one functional unit.
// It picks a free slot for each new instruction, captures pending operands from the
// CDB (including a bypass for an instruction allocating in the broadcast cycle), and
// presents the oldest ready entry to the FU over a valid/ready handshake.
module rs_bank #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = 4,
    parameter int DATA_W      = 32,
    parameter int OP_W        = 3,
    parameter int BR_W        = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 alloc_valid,
    output logic                                 alloc_ready,
    input  logic [TAG_W-1:0]                     alloc_qj,
    input  logic [TAG_W-1:0]                     alloc_qk,
    input  logic [DATA_W-1:0]                    alloc_vj,
    input  logic [DATA_W-1:0]                    alloc_vk,
    input  logic [TAG_W-1:0]                     alloc_rob,
    input  logic [OP_W-1:0]                      alloc_op,
    input  logic [BR_W-1:0]                      alloc_br,
    input  logic                                 alloc_load,
    input  logic                                 cdb_valid,
    input  logic [TAG_W-1:0]                     cdb_tag,
    input  logic [DATA_W-1:0]                    cdb_data,
    input  logic                                 cdb_load_step1,
    output logic                                 issue_valid,
    input  logic                                 issue_ready,
    output logic [TAG_W-1:0]                     issue_rob,
    output logic [OP_W-1:0]                      issue_op,
    output logic [BR_W-1:0]                      issue_br,
    output logic                                 issue_load,
    output logic [DATA_W-1:0]                    issue_vj,
    output logic [DATA_W-1:0]                    issue_vk,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]     occupancy
);

    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]       qj_q  [NUM_ENTRIES];
    logic [TAG_W-1:0]       qj_d  [NUM_ENTRIES];
    logic [TAG_W-1:0]       qk_q  [NUM_ENTRIES];
    logic [TAG_W-1:0]       qk_d  [NUM_ENTRIES];
    logic [DATA_W-1:0]      vj_q  [NUM_ENTRIES];
    logic [DATA_W-1:0]      vj_d  [NUM_ENTRIES];
    logic [DATA_W-1:0]      vk_q  [NUM_ENTRIES];
    logic [DATA_W-1:0]      vk_d  [NUM_ENTRIES];
    logic [TAG_W-1:0]       rob_q [NUM_ENTRIES];
    logic [TAG_W-1:0]       rob_d [NUM_ENTRIES];
    logic [OP_W-1:0]        op_q  [NUM_ENTRIES];
    logic [OP_W-1:0]        op_d  [NUM_ENTRIES];
    logic [BR_W-1:0]        br_q  [NUM_ENTRIES];
    logic [BR_W-1:0]        br_d  [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] load_q, load_d;
    // older_q[j][i] set means entry j was allocated before entry i.
    logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] older_d [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] ready;
    logic [NUM_ENTRIES-1:0] grant;
    logic [NUM_ENTRIES-1:0] alloc_oh;
    logic                   alloc_found;
    logic                   alloc_fire;
    logic                   issue_fire;
    logic                   cdb_wake;
    logic [CNT_W-1:0]       occ_cnt;

    // Handshake qualifiers; alloc_ready looks only at registered valid bits so a
    // slot being issued this cycle is not offered until the next one.
    assign alloc_ready = ~&valid_q;
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    assign issue_fire  = issue_valid && issue_ready;
    assign cdb_wake    = cdb_valid && !cdb_load_step1 && (cdb_tag != '0);
    assign occupancy   = occ_cnt;

    // Readiness and oldest-ready selection: an entry wins unless an older ready one exists.
    always_comb begin
        ready = '0;
        grant = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ready[i] = valid_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (j != i && ready[j] && older_q[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    // Present the granted entry; all zeros when nothing is ready.
    always_comb begin
        issue_valid = |ready;
        issue_rob   = '0;
        issue_op    = '0;
        issue_br    = '0;
        issue_load  = 1'b0;
        issue_vj    = '0;
        issue_vk    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (grant[i]) begin
                issue_rob  = rob_q[i];
                issue_op   = op_q[i];
                issue_br   = br_q[i];
                issue_load = load_q[i];
                issue_vj   = vj_q[i];
                issue_vk   = vk_q[i];
            end
        end
    end

    // Lowest-index free slot and population count of valid entries.
    always_comb begin
        alloc_oh    = '0;
        alloc_found = 1'b0;
        occ_cnt     = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_oh[i] = 1'b1;
                alloc_found = 1'b1;
            end
            occ_cnt = occ_cnt + CNT_W'(valid_q[i]);
        end
    end

    // Next state: wakeup, issue free, allocation with bypass, then flush overriding all.
    always_comb begin
        valid_d = valid_q;
        load_d  = load_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        rob_d   = rob_q;
        op_d    = op_q;
        br_d    = br_q;
        older_d = older_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cdb_wake && valid_q[i]) begin
                if (qj_q[i] == cdb_tag) begin
                    qj_d[i] = '0;
                    vj_d[i] = cdb_data;
                end
                if (qk_q[i] == cdb_tag) begin
                    qk_d[i] = '0;
                    vk_d[i] = cdb_data;
                end
            end
            if (issue_fire && grant[i]) begin
                valid_d[i] = 1'b0;
            end
            if (alloc_fire && alloc_oh[i]) begin
                valid_d[i] = 1'b1;
                rob_d[i]   = alloc_rob;
                op_d[i]    = alloc_op;
                br_d[i]    = alloc_br;
                load_d[i]  = alloc_load;
                if (cdb_wake && alloc_qj == cdb_tag) begin
                    qj_d[i] = '0;
                    vj_d[i] = cdb_data;
                end else begin
                    qj_d[i] = alloc_qj;
                    vj_d[i] = alloc_vj;
                end
                if (cdb_wake && alloc_qk == cdb_tag) begin
                    qk_d[i] = '0;
                    vk_d[i] = cdb_data;
                end else begin
                    qk_d[i] = alloc_qk;
                    vk_d[i] = alloc_vk;
                end
                // The newcomer is younger than every other slot.
                older_d[i] = '0;
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    if (j != i) begin
                        older_d[j][i] = 1'b1;
                    end
                end
            end
        end
        if (flush) begin
            valid_d = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                older_d[i] = '0;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            load_q  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                rob_q[i]   <= '0;
                op_q[i]    <= '0;
                br_q[i]    <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            load_q  <= load_d;
            qj_q    <= qj_d;
            qk_q    <= qk_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            rob_q   <= rob_d;
            op_q    <= op_d;
            br_q    <= br_d;
            older_q <= older_d;
        end
    end

endmodule

// File: tb/tb_rs_bank.sv
// Directed testbench for rs_bank with the default 4-entry configuration.
module tb_rs_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_qj, alloc_qk, alloc_rob;
    logic [31:0] alloc_vj, alloc_vk;
    logic [2:0]  alloc_op;
    logic [1:0]  alloc_br;
    logic        alloc_load;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_load_step1;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_rob;
    logic [2:0]  issue_op;
    logic [1:0]  issue_br;
    logic        issue_load;
    logic [31:0] issue_vj, issue_vk;
    logic [2:0]  occupancy;

    int total = 0;
    int bad   = 0;

    rs_bank dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_qj(alloc_qj), .alloc_qk(alloc_qk), .alloc_vj(alloc_vj), .alloc_vk(alloc_vk),
        .alloc_rob(alloc_rob), .alloc_op(alloc_op), .alloc_br(alloc_br), .alloc_load(alloc_load),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_load_step1(cdb_load_step1),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rob(issue_rob),
        .issue_op(issue_op), .issue_br(issue_br), .issue_load(issue_load),
        .issue_vj(issue_vj), .issue_vk(issue_vk), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        flush          = 1'b0;
        alloc_valid    = 1'b0;
        alloc_qj       = '0;
        alloc_qk       = '0;
        alloc_vj       = '0;
        alloc_vk       = '0;
        alloc_rob      = '0;
        alloc_op       = '0;
        alloc_br       = '0;
        alloc_load     = 1'b0;
        cdb_valid      = 1'b0;
        cdb_tag        = '0;
        cdb_data       = '0;
        cdb_load_step1 = 1'b0;
        issue_ready    = 1'b0;
    endtask

    task automatic drive_alloc(input logic [3:0] rob, input logic [3:0] qj, input logic [3:0] qk,
                               input logic [31:0] vj, input logic [31:0] vk);
        alloc_valid = 1'b1;
        alloc_rob   = rob;
        alloc_qj    = qj;
        alloc_qk    = qk;
        alloc_vj    = vj;
        alloc_vk    = vk;
        alloc_op    = rob[2:0];
        alloc_br    = rob[1:0];
        alloc_load  = rob[0];
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        repeat (2) tick();
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready got=%0h exp=1", alloc_ready); end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid got=%0h exp=0", issue_valid); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        total++; if (issue_rob !== 4'd0 || issue_vj !== 32'd0 || issue_vk !== 32'd0 || issue_op !== 3'd0)
            begin bad++; $display("FAIL reset_issue_data got rob=%0h vj=%0h vk=%0h op=%0h exp all 0", issue_rob, issue_vj, issue_vk, issue_op); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        issue_ready = 1'b1;
        drive_alloc(4'd3, 4'd0, 4'd0, 32'd5, 32'd7);
        tick();
        alloc_valid = 1'b0;
        total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL basic_issue_valid got=%0h exp=1", issue_valid); end
        total++; if (issue_rob !== 4'd3) begin bad++; $display("FAIL basic_rob got=%0h exp=3", issue_rob); end
        total++; if (issue_vj !== 32'd5 || issue_vk !== 32'd7) begin bad++; $display("FAIL basic_operands got vj=%0h vk=%0h exp 5 7", issue_vj, issue_vk); end
        total++; if (issue_op !== 3'd3 || issue_br !== 2'd3 || issue_load !== 1'b1)
            begin bad++; $display("FAIL basic_fields got op=%0h br=%0h ld=%0h exp 3 3 1", issue_op, issue_br, issue_load); end
        tick();
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL basic_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_wakeup();
        issue_ready = 1'b1;
        drive_alloc(4'd4, 4'd2, 4'd0, 32'd0, 32'd1);
        tick();
        alloc_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'hAB;
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wake_cdb_cycle got=%0h exp=0", issue_valid); end
        tick();
        cdb_valid = 1'b0;
        total++; if (issue_valid !== 1'b1 || issue_vj !== 32'hAB || issue_rob !== 4'd4)
            begin bad++; $display("FAIL wake_after got v=%0h vj=%0h rob=%0h exp 1 ab 4", issue_valid, issue_vj, issue_rob); end
        tick();
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL wake_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_bypass();
        issue_ready = 1'b1;
        drive_alloc(4'd5, 4'd0, 4'd6, 32'd2, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'h11;
        tick();
        alloc_valid = 1'b0; cdb_valid = 1'b0;
        total++; if (issue_valid !== 1'b1 || issue_vk !== 32'h11 || issue_rob !== 4'd5)
            begin bad++; $display("FAIL bypass got v=%0h vk=%0h rob=%0h exp 1 11 5", issue_valid, issue_vk, issue_rob); end
        tick();
        drive_alloc(4'd5, 4'd0, 4'd6, 32'd2, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'h11; cdb_load_step1 = 1'b1;
        tick();
        alloc_valid = 1'b0; cdb_valid = 1'b0; cdb_load_step1 = 1'b0;
        total++; if (issue_valid !== 1'b0 || occupancy !== 3'd1)
            begin bad++; $display("FAIL step1_ignored got v=%0h occ=%0d exp 0 1", issue_valid, occupancy); end
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'h22;
        tick();
        cdb_valid = 1'b0;
        total++; if (issue_valid !== 1'b1 || issue_vk !== 32'h22)
            begin bad++; $display("FAIL step1_later_wake got v=%0h vk=%0h exp 1 22", issue_valid, issue_vk); end
        tick();
    endtask

    task automatic test_tag0();
        issue_ready = 1'b0;
        drive_alloc(4'd6, 4'd0, 4'd0, 32'd5, 32'd9);
        tick();
        alloc_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'hFF;
        tick();
        cdb_valid = 1'b0;
        total++; if (issue_vj !== 32'd5 || issue_vk !== 32'd9)
            begin bad++; $display("FAIL tag0_no_wake got vj=%0h vk=%0h exp 5 9", issue_vj, issue_vk); end
        issue_ready = 1'b1;
        tick();
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL tag0_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_fill_order();
        issue_ready = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            drive_alloc(4'(r), 4'd9, 4'd0, 32'd0, 32'(r));
            tick();
        end
        alloc_valid = 1'b0;
        total++; if (alloc_ready !== 1'b0 || occupancy !== 3'd4 || issue_valid !== 1'b0)
            begin bad++; $display("FAIL fill_full got ar=%0h occ=%0d iv=%0h exp 0 4 0", alloc_ready, occupancy, issue_valid); end
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h99;
        tick();
        cdb_valid = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            total++; if (issue_valid !== 1'b1 || issue_rob !== 4'(r) || issue_vj !== 32'h99)
                begin bad++; $display("FAIL fill_order got v=%0h rob=%0h vj=%0h exp 1 %0h 99", issue_valid, issue_rob, issue_vj, r); end
            tick();
        end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL fill_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_full_bank();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'd2, 4'd3, 4'd4, 4'd7};
        issue_ready = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            drive_alloc(4'(r), 4'd0, 4'd0, 32'(r * 16), 32'd0);
            tick();
        end
        alloc_valid = 1'b0;
        total++; if (alloc_ready !== 1'b0 || issue_rob !== 4'd1)
            begin bad++; $display("FAIL full_state got ar=%0h rob=%0h exp 0 1", alloc_ready, issue_rob); end
        issue_ready = 1'b1;
        drive_alloc(4'd8, 4'd0, 4'd0, 32'h80, 32'd0);
        tick();
        alloc_valid = 1'b0; issue_ready = 1'b0;
        total++; if (occupancy !== 3'd3 || alloc_ready !== 1'b1 || issue_rob !== 4'd2)
            begin bad++; $display("FAIL full_issue_no_alloc got occ=%0d ar=%0h rob=%0h exp 3 1 2", occupancy, alloc_ready, issue_rob); end
        tick();
        total++; if (issue_valid !== 1'b1 || issue_rob !== 4'd2 || issue_vj !== 32'h20)
            begin bad++; $display("FAIL full_hold_stable got v=%0h rob=%0h vj=%0h exp 1 2 20", issue_valid, issue_rob, issue_vj); end
        drive_alloc(4'd7, 4'd0, 4'd0, 32'h70, 32'd0);
        tick();
        alloc_valid = 1'b0;
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++; if (issue_rob !== exp_seq[k])
                begin bad++; $display("FAIL age_order got rob=%0h exp=%0h", issue_rob, exp_seq[k]); end
            tick();
        end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL age_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_simultaneous();
        issue_ready = 1'b0;
        drive_alloc(4'd1, 4'd0, 4'd0, 32'd1, 32'd1);
        tick();
        issue_ready = 1'b1;
        drive_alloc(4'd2, 4'd8, 4'd0, 32'd0, 32'd3);
        cdb_valid = 1'b1; cdb_tag = 4'd8; cdb_data = 32'h55;
        tick();
        alloc_valid = 1'b0; cdb_valid = 1'b0; issue_ready = 1'b0;
        total++; if (occupancy !== 3'd1 || issue_rob !== 4'd2 || issue_vj !== 32'h55)
            begin bad++; $display("FAIL simul got occ=%0d rob=%0h vj=%0h exp 1 2 55", occupancy, issue_rob, issue_vj); end
        issue_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush_reset();
        issue_ready = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            drive_alloc(4'(r), 4'd9, 4'd0, 32'd0, 32'd0);
            tick();
        end
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d exp=3", occupancy); end
        drive_alloc(4'd4, 4'd0, 4'd0, 32'd4, 32'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0; alloc_valid = 1'b0;
        total++; if (occupancy !== 3'd0 || issue_valid !== 1'b0 || alloc_ready !== 1'b1)
            begin bad++; $display("FAIL flush_clear got occ=%0d iv=%0h ar=%0h exp 0 0 1", occupancy, issue_valid, alloc_ready); end
        for (int r = 1; r <= 2; r++) begin
            drive_alloc(4'(r), 4'd0, 4'd0, 32'd1, 32'd1);
            tick();
        end
        alloc_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        total++; if (occupancy !== 3'd0 || issue_valid !== 1'b0)
            begin bad++; $display("FAIL async_reset got occ=%0d iv=%0h exp 0 0", occupancy, issue_valid); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_tag0();
        test_fill_order();
        test_full_bank();
        test_simultaneous();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
